// File: rtl/wide_add_seq_pkg.sv
// Shared constants and state encoding for the
// wide sequential adder.
package wide_add_seq_pkg;

  localparam int DATA_W_DEF = 256;
  localparam int DIG_W_DEF  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/wide_add_seq_rca_digit.sv
// One-bit full adder cell and the digit-wide
// ripple-carry adder chained from it.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module rca_digit #(
  parameter int W = 64
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;
  assign cout = c[W];

  for (genvar i = 0; i < W; i++) begin : g_bit
    fa_cell u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

endmodule

// File: rtl/wide_add_seq.sv
// Digit-serial add/subtract: one DIG_W digit
// per cycle, LSB first, through one rca_digit.
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIG_W  = DIG_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sub,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] s,
  output logic              c_out
);

  localparam int NUM_DIG = DATA_W / DIG_W;
  localparam int CNT_W   = $clog2(NUM_DIG);
  localparam logic [CNT_W-1:0] LAST_K =
    CNT_W'(NUM_DIG - 1);

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] s_q;
  logic [CNT_W-1:0]  k_q;
  logic              carry_q;
  logic [DIG_W-1:0]  x_dig;
  logic [DIG_W-1:0]  y_dig;
  logic [DIG_W-1:0]  sum_dig;
  logic              cout_dig;
  logic              last_k;

  assign last_k = (k_q == LAST_K);
  assign x_dig  = a_q[DIG_W*int'(k_q) +: DIG_W];
  assign y_dig  = b_q[DIG_W*int'(k_q) +: DIG_W];

  rca_digit #(
    .W (DIG_W)
  ) u_rca (
    .x    (x_dig),
    .y    (y_dig),
    .cin  (carry_q),
    .s    (sum_dig),
    .cout (cout_dig)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and status outputs.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_k) state_nx = FIN;
      end
      FIN: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture and per-digit accumulate;
  // b is stored pre-inverted for subtract.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b ^ {DATA_W{sub}};
            k_q     <= '0;
            carry_q <= sub;
          end
        end
        RUN: begin
          s_q[DIG_W*int'(k_q) +: DIG_W] <= sum_dig;
          carry_q <= cout_dig;
          k_q     <= k_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign s     = s_q;
  assign c_out = carry_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed and random checks for wide_add_seq:
// results, latency, done width, busy and reset.
module tb_wide_add_seq;

  localparam int DW = 256;
  localparam int GW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          sub;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          busy;
  logic          done;
  logic [DW-1:0] s;
  logic          c_out;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wide_add_seq #(
    .DATA_W (DW),
    .DIG_W  (GW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .c_out (c_out)
  );

  task automatic chk(input string tag,
                     input logic [DW:0] got,
                     input logic [DW:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_w();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++)
      v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // mode 0: plain; 1: scramble inputs after
  // start; 2: keep pulsing start while busy.
  task automatic run_op(input string tag,
                        input logic [DW-1:0] ta,
                        input logic [DW-1:0] tb,
                        input logic ts,
                        input logic [DW-1:0] es,
                        input logic ec,
                        input int mode,
                        input bit hold_chk);
    int lat;
    @(negedge clk);
    a = ta; b = tb; sub = ts; start = 1'b1;
    @(negedge clk);
    lat = 1;
    if (mode == 2) begin
      a = ~ta; b = ta ^ tb; sub = ~ts;
    end else begin
      start = 1'b0;
    end
    if (mode == 1) begin
      a = rnd_w(); b = rnd_w(); sub = ~ts;
    end
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
      if (mode == 2) a = a + 1'b1;
    end
    chk({tag, " lat"}, lat, 5);
    chk({tag, " s"}, s, es);
    chk({tag, " c_out"}, c_out, ec);
    @(negedge clk);
    start = 1'b0;
    chk({tag, " done1"}, done, 0);
    if (hold_chk) begin
      chk({tag, " idle"}, busy, 0);
      @(negedge clk);
      chk({tag, " hold s"}, s, es);
      chk({tag, " hold c"}, c_out, ec);
    end
  endtask

  logic [DW-1:0] ones;
  logic [DW-1:0] ra, rb, es;
  logic [DW:0]   w;
  logic          rs, ec;

  initial begin
    ones  = '1;
    reset = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst s", s, 0);
    chk("rst c", c_out, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_op("add3+4", 256'd3, 256'd4, 1'b0,
           256'd7, 1'b0, 0, 1'b1);
    run_op("ripple", ones, 256'd1, 1'b0,
           256'd0, 1'b1, 0, 1'b1);
    run_op("sub0-1", 256'd0, 256'd1, 1'b1,
           ones, 1'b0, 0, 1'b1);
    run_op("sub5-5", 256'd5, 256'd5, 1'b1,
           256'd0, 1'b1, 0, 1'b1);
    run_op("xdig", 256'hFFFF_FFFF_FFFF_FFFF,
           256'd1, 1'b0,
           256'h1_0000_0000_0000_0000, 1'b0,
           1, 1'b1);
    run_op("busy", 256'd100, 256'd58, 1'b1,
           256'd42, 1'b1, 2, 1'b1);

    // Reset during RUN digit k=2.
    @(negedge clk);
    a = ones; b = ones; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid busy", busy, 0);
    chk("mid done", done, 0);
    chk("mid s", s, 0);
    chk("mid c", c_out, 0);
    @(negedge clk);
    reset = 1'b1;
    run_op("post", 256'd9, 256'd10, 1'b1,
           ones, 1'b0, 0, 1'b1);

    for (int i = 0; i < 4000; i++) begin
      ra = rnd_w();
      rb = (i % 16 == 0) ? ra : rnd_w();
      rs = $urandom_range(0, 1);
      if (rs) begin
        es = ra - rb;
        ec = (ra >= rb);
      end else begin
        w  = {1'b0, ra} + {1'b0, rb};
        es = w[DW-1:0];
        ec = w[DW];
      end
      run_op("rand", ra, rb, rs, es, ec, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
